// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store controller for a word-only DataMemory
module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic [31:0] LoadData,
  output logic        Done,
  output logic        Stall,
  output logic        Misaligned,
  output logic        OutOfRange,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_data;

  logic        is_load;
  logic        is_sw;
  logic        is_sub_store;
  logic        mis;
  logic        oor;
  logic        fault;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Decode the request class and trap misaligned / out-of-range addresses
  always_comb begin
    is_load      = (Op <= OP_LBU);
    is_sw        = (Op == OP_SW);
    is_sub_store = (Op == OP_SH) || (Op == OP_SB);
    mis = (((Op == OP_LW) || (Op == OP_SW)) && (Addr[1:0] != 2'b00)) ||
          (((Op == OP_LH) || (Op == OP_LHU) || (Op == OP_SH)) && Addr[0]);
    oor   = (Addr >= 32'(MEM_BYTES));
    fault = mis || oor;
  end

  // Little-endian lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    half_lane = Addr[1] ? MemReadData[31:16] : MemReadData[15:0];
    byte_lane = MemReadData[{Addr[1:0], 3'b000} +: 8];
    case (Op)
      OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_val = {16'h0000, half_lane};
      OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_val = {24'h000000, byte_lane};
      default: load_val = MemReadData;
    endcase
    merged = MemReadData;
    if (Op == OP_SH) begin
      if (Addr[1]) merged[31:16] = StoreData[15:0];
      else         merged[15:0]  = StoreData[15:0];
    end else begin
      merged[{Addr[1:0], 3'b000} +: 8] = StoreData[7:0];
    end
  end

  // Memory-side strobes; everything is forced quiet while reset is held
  always_comb begin
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Stall        = 1'b0;
    MemAddress   = {Addr[31:2], 2'b00};
    MemWriteData = StoreData;
    if (state == RMW_WR) begin
      MemAddress   = rmw_addr;
      MemWriteData = rmw_data;
    end
    if (Reset) begin
      if (state == RMW_WR) begin
        MemWrite = 1'b1;
      end else if (Req && !fault) begin
        MemRead  = is_load || is_sub_store;
        MemWrite = is_sw;
        Stall    = is_sub_store;
      end
    end
  end

  // Control FSM with registered completion/fault pulses and load result
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      rmw_addr   <= '0;
      rmw_data   <= '0;
      LoadData   <= '0;
      Done       <= 1'b0;
      Misaligned <= 1'b0;
      OutOfRange <= 1'b0;
    end else begin
      Done       <= 1'b0;
      Misaligned <= 1'b0;
      OutOfRange <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            if (fault) begin
              Done       <= 1'b1;
              Misaligned <= mis;
              OutOfRange <= !mis;
            end else if (is_sub_store) begin
              rmw_addr <= {Addr[31:2], 2'b00};
              rmw_data <= merged;
              state    <= RMW_WR;
            end else begin
              Done <= 1'b1;
              if (is_load) LoadData <= load_val;
            end
          end
        end
        RMW_WR: begin
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard testbench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011;
  localparam logic [2:0] LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] Addr = '0;
  logic [31:0] StoreData = '0;
  logic [31:0] LoadData;
  logic        Done;
  logic        Stall;
  logic        Misaligned;
  logic        OutOfRange;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  typedef struct packed {
    logic [31:0] ld;
    logic        mis;
    logic        oor;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_ld = '0;
  logic [31:0] mem [0:1023];

  dmem_access_ctrl #(.MEM_BYTES(4096)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr),
    .StoreData(StoreData), .LoadData(LoadData), .Done(Done), .Stall(Stall),
    .Misaligned(Misaligned), .OutOfRange(OutOfRange), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  assign MemReadData = mem[MemAddress[11:2]];

  always @(posedge Clk) begin
    if (MemWrite) mem[MemAddress[11:2]] <= MemWriteData;
  end

  // Completion monitor: every Done pulse is matched against the oldest expectation
  always @(negedge Clk) begin
    if (Reset) begin
      if (Done) begin
        exp_t e;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: Done=1 with no outstanding request");
        end else begin
          e = sb_q.pop_front();
          if (LoadData !== e.ld || Misaligned !== e.mis || OutOfRange !== e.oor) begin
            fails++;
            $display("FAIL done_result: LoadData=%h mis=%b oor=%b, expected %h mis=%b oor=%b",
                     LoadData, Misaligned, OutOfRange, e.ld, e.mis, e.oor);
          end
        end
      end else if (Misaligned || OutOfRange) begin
        tests++;
        fails++;
        $display("FAIL flag_without_done: mis=%b oor=%b", Misaligned, OutOfRange);
      end
    end
  end

  // Issue one request; exp is the load result for loads or the merged word for SH/SB
  task automatic op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] exp, input logic mis, input logic oor);
    logic is_load;
    exp_t e;
    is_load = (o <= LBU);
    @(posedge Clk); #1;
    Req = 1'b1; Op = o; Addr = a; StoreData = d;
    if (is_load && !mis && !oor) last_ld = exp;
    e.ld = last_ld; e.mis = mis; e.oor = oor;
    sb_q.push_back(e);
    #2;
    tests++;
    if (mis || oor) begin
      if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Stall !== 1'b0) begin
        fails++;
        $display("FAIL fault_quiet: rd=%b wr=%b stall=%b, expected all 0", MemRead, MemWrite, Stall);
      end
    end else if (is_load) begin
      if (MemRead !== 1'b1 || MemWrite !== 1'b0 || Stall !== 1'b0 || MemAddress !== {a[31:2], 2'b00}) begin
        fails++;
        $display("FAIL load_strobe: rd=%b wr=%b stall=%b addr=%h, expected 1 0 0 %h",
                 MemRead, MemWrite, Stall, MemAddress, {a[31:2], 2'b00});
      end
    end else if (o == SW) begin
      if (MemWrite !== 1'b1 || MemRead !== 1'b0 || Stall !== 1'b0 || MemWriteData !== d) begin
        fails++;
        $display("FAIL sw_strobe: wr=%b rd=%b stall=%b data=%h, expected 1 0 0 %h",
                 MemWrite, MemRead, Stall, MemWriteData, d);
      end
    end else begin
      if (MemRead !== 1'b1 || MemWrite !== 1'b0 || Stall !== 1'b1) begin
        fails++;
        $display("FAIL rmw_read: rd=%b wr=%b stall=%b, expected 1 0 1", MemRead, MemWrite, Stall);
      end
      @(posedge Clk); #3;
      tests++;
      if (MemWrite !== 1'b1 || MemRead !== 1'b0 || Stall !== 1'b0 ||
          MemWriteData !== exp || MemAddress !== {a[31:2], 2'b00}) begin
        fails++;
        $display("FAIL rmw_write: wr=%b rd=%b stall=%b data=%h addr=%h, expected 1 0 0 %h %h",
                 MemWrite, MemRead, Stall, MemWriteData, MemAddress, exp, {a[31:2], 2'b00});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      Req = 1'b0;
      #2;
      tests++;
      if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Stall !== 1'b0) begin
        fails++;
        $display("FAIL idle_quiet: rd=%b wr=%b stall=%b, expected 0 0 0", MemRead, MemWrite, Stall);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Req = 1'b1; Op = SB; Addr = 32'h8; StoreData = 32'hFF;
    repeat (2) @(posedge Clk);
    #3;
    tests++;
    if (LoadData !== 32'h0 || Done !== 1'b0 || Misaligned !== 1'b0 || OutOfRange !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: ld=%h done=%b mis=%b oor=%b, expected 0", LoadData, Done, Misaligned, OutOfRange);
    end
    tests++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: rd=%b wr=%b stall=%b, expected 0", MemRead, MemWrite, Stall);
    end
    Reset = 1'b1; Req = 1'b0;
    idle(2);
  endtask

  task automatic test_loads();
    op(SW,  32'h8, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
    op(LW,  32'h8, 32'h0, 32'h80FF7F01, 1'b0, 1'b0);
    op(LB,  32'hB, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    op(LBU, 32'hB, 32'h0, 32'h00000080, 1'b0, 1'b0);
    op(LH,  32'hA, 32'h0, 32'hFFFF80FF, 1'b0, 1'b0);
    op(LHU, 32'h8, 32'h0, 32'h00007F01, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_sb();
    op(SB, 32'h9, 32'h000000AA, 32'h80FFAA01, 1'b0, 1'b0);
    op(LW, 32'h8, 32'h0, 32'h80FFAA01, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_sh_misaligned();
    op(SH, 32'hA, 32'h00001234, 32'h1234AA01, 1'b0, 1'b0);
    op(LW, 32'h8, 32'h0, 32'h1234AA01, 1'b0, 1'b0);
    op(SH, 32'h9, 32'h00005678, 32'h0, 1'b1, 1'b0);
    op(LW, 32'h8, 32'h0, 32'h1234AA01, 1'b0, 1'b0);
    op(LW, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic test_out_of_range();
    op(LW, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b1);
    op(LW, 32'h1001, 32'h0, 32'h0, 1'b1, 1'b0);
    op(SW, 32'h1000, 32'h11111111, 32'h0, 1'b0, 1'b1);
    op(LW, 32'hFFC, 32'h0, 32'h0, 1'b0, 1'b0);
    op(SB, 32'hFFFFFFFF, 32'h22, 32'h0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic test_back_to_back();
    op(SW,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    op(LW,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    op(LBU, 32'h11, 32'h0, 32'h000000BE, 1'b0, 1'b0);
    op(LH,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b0);
    op(SB,  32'h13, 32'h0000007E, 32'h7EADBEEF, 1'b0, 1'b0);
    op(LB,  32'h13, 32'h0, 32'h0000007E, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_reset_rmw();
    @(posedge Clk); #1;
    Req = 1'b1; Op = SB; Addr = 32'h9; StoreData = 32'h55;
    #2;
    tests++;
    if (Stall !== 1'b1 || MemRead !== 1'b1) begin
      fails++;
      $display("FAIL rst_rmw_read: stall=%b rd=%b, expected 1 1", Stall, MemRead);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    #2;
    tests++;
    if (MemWrite !== 1'b0 || Stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_rmw_write: wr=%b stall=%b, expected 0 0", MemWrite, Stall);
    end
    @(posedge Clk); #1;
    Reset = 1'b1; Req = 1'b0;
    last_ld = 32'h0;
    #2;
    tests++;
    if (LoadData !== 32'h0 || Done !== 1'b0) begin
      fails++;
      $display("FAIL rst_rmw_regs: ld=%h done=%b, expected 0 0", LoadData, Done);
    end
    op(LW, 32'h8, 32'h0, 32'h1234AA01, 1'b0, 1'b0);
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_sb();
    test_sh_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_rmw();
    idle(2);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL missing_done: %0d requests never completed, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Controller between the pipeline MEM stage and the word-only DataMemory. Decodes MIPS load/store width (LW/LH/LHU/LB/LBU/SW/SH/SB) and performs byte-lane extraction with sign or zero extension. Sub-word stores are executed as a two-cycle read-modify-write, and the controller raises Stall to hold the pipeline during the read cycle. Misaligned and out-of-range accesses are trapped before they reach memory.

Parameters:
MEM_BYTES, 4096, size of DataMemory in bytes; any byte address >= MEM_BYTES is out of range.

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-low reset
Req  in  1  MEM stage has a memory operation this cycle
Op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
Addr  in  32  byte address from ALU
StoreData  in  32  rt value; sub-word data taken from the low bits
LoadData  out  32  registered, extended load result
Done  out  1  registered one-cycle pulse: operation completed or faulted
Stall  out  1  combinational; pipeline must hold MEM stage and the request
Misaligned  out  1  registered one-cycle pulse with Done
OutOfRange  out  1  registered one-cycle pulse with Done
MemAddress  out  32  word-aligned address {A[31:2],2'b00} to DataMemory
MemWriteData  out  32  word to write
MemWrite  out  1  DataMemory write enable; write occurs at the rising edge
MemRead  out  1  DataMemory read enable
MemReadData  in  32  DataMemory read data, combinational from MemAddress

Behaviour:
- Reset (Reset==0 at rising edge): state=IDLE; LoadData=0, Done=0, Misaligned=0, OutOfRange=0; internal latches cleared.
- Reset overrides everything, including an in-flight RMW: the pending write is dropped and DataMemory is unchanged.
- While Reset is low, MemRead, MemWrite and Stall are 0.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k=Addr[1:0]; halfword uses bits [15:0] if Addr[1]==0, else [31:16].
- Fault check in IDLE, with Req=1:
  - Misaligned if LW/SW and Addr[1:0]!=0, or LH/LHU/SH and Addr[0]==1.
  - Otherwise OutOfRange if Addr >= MEM_BYTES.
  - On either fault: no MemRead or MemWrite; next cycle Done=1 plus the matching flag; LoadData unchanged; Stall=0.
  - Misaligned takes priority over OutOfRange.
- IDLE, load (LW/LH/LHU/LB/LBU), no fault:
  - MemRead=1 and MemAddress driven combinationally in the same cycle.
  - At the edge, LoadData <= extracted lane: LH/LB sign-extend, LHU/LBU zero-extend.
  - Done=1 the next cycle. Stall=0 (single-cycle).
- IDLE, SW, no fault: MemWrite=1, MemWriteData=StoreData in the same cycle; Done next cycle; Stall=0.
- IDLE, SH/SB, no fault (cycle 0):
  - MemRead=1, Stall=1.
  - At the edge: latch word address and merged word (MemReadData with the selected lane replaced by StoreData[15:0] or [7:0]); go to RMW_WR.
- RMW_WR (cycle 1):
  - MemWrite=1, MemAddress=latched address, MemWriteData=merged word, Stall=0.
  - Req/Op/Addr ignored (the same held request is still present); next state IDLE; Done=1 the following cycle.
- Req=0 in IDLE: no memory enables; Done=0.
- MemRead and MemWrite are never both 1 in the same cycle.
- Done, Misaligned and OutOfRange are never high for more than one consecutive cycle per request.
- Back-to-back requests on consecutive cycles in IDLE are each accepted; Done pulses on consecutive cycles.
- Latency (request to Done): 1 cycle for loads, SW and faults; 2 cycles for SH/SB.

Test Plan:
- Reset low 2 cycles, then high -> all registered outputs 0, state IDLE; Req=0 gives no MemRead or MemWrite.
- SW Addr=0x8, StoreData=0x80FF7F01, then LW 0x8 -> LoadData=0x80FF7F01; LB 0xB -> 0xFFFFFF80; LBU 0xB -> 0x00000080; LH 0xA -> 0xFFFF80FF; LHU 0x8 -> 0x00007F01.
- SB Addr=0x9, StoreData=0x000000AA onto word 0x80FF7F01 -> Stall=1 for exactly 1 cycle, MemWrite with 0x80FFAA01 in cycle 1, Done in cycle 2; LW 0x8 -> 0x80FFAA01.
- SH Addr=0xA, StoreData=0x1234 -> word becomes 0x1234AA01; SH Addr=0x9 -> Misaligned=1, Done=1, memory unchanged; LW Addr=0x6 -> Misaligned=1.
- LW Addr=0x1000 with MEM_BYTES=4096 -> OutOfRange=1, Done=1, MemRead never asserted; LW 0x1001 -> Misaligned only.
- SB issued, Reset driven low during RMW_WR -> no write occurs; after release, LW of that address returns the pre-SB value.
